vga_pattern_gen: RTL and testbench

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

---
 rtl/vga_pkg.sv | 16 +
 rtl/vga_pattern_gen_if.sv | 23 ++
 rtl/vga_pattern_gen_mode_ctrl.sv | 51 +++++
 rtl/vga_pattern_gen.sv | 78 +++++++
 tb/tb_vga_pattern_gen.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared types for the VGA test-pattern generator: pattern modes and FSM states.
package vga_pkg;
  localparam int COLOR_W_DEF = 4;

  typedef enum logic [1:0] {
    MODE_GRADIENT = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_SOLID    = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } mode_st_e;
endpackage

// File: rtl/vga_pattern_gen_if.sv
// Mode-request bus between the pattern datapath (master) and the mode controller (slave).
interface vga_mode_if
  import vga_pkg::*;
#(
  parameter int FCNT_W = 8
) ();
  mode_e             mode_req;
  logic              mode_req_valid;
  logic              frame_end;
  logic              mode_busy;
  mode_e             active_mode;
  logic [FCNT_W-1:0] frame_cnt;

  modport master (
    output mode_req, mode_req_valid, frame_end,
    input  mode_busy, active_mode, frame_cnt
  );

  modport slave (
    input  mode_req, mode_req_valid, frame_end,
    output mode_busy, active_mode, frame_cnt
  );
endinterface

// File: rtl/vga_pattern_gen_mode_ctrl.sv
// Mode controller: holds a pending request and commits it only at frame boundaries,
// plus the completed-frame counter.
module vga_mode_ctrl
  import vga_pkg::*;
#(
  parameter int FCNT_W = 8
) (
  input logic       clk,
  input logic       reset,
  vga_mode_if.slave ctl
);
  mode_st_e          state, state_nxt;
  mode_e             pending, pending_nxt;
  mode_e             active, active_nxt;
  logic [FCNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      pending <= MODE_GRADIENT;
      active  <= MODE_GRADIENT;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      active  <= active_nxt;
      cnt     <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    active_nxt  = active;
    cnt_nxt     = cnt;
    if (ctl.frame_end) cnt_nxt = cnt + FCNT_W'(1);
    // Commit the old pending value first so a request landing on frame_end waits a frame.
    if (state == ST_PENDING && ctl.frame_end) begin
      active_nxt = pending;
      state_nxt  = ST_IDLE;
    end
    if (ctl.mode_req_valid) begin
      pending_nxt = ctl.mode_req;
      state_nxt   = ST_PENDING;
    end
  end

  assign ctl.mode_busy   = (state == ST_PENDING);
  assign ctl.active_mode = active;
  assign ctl.frame_cnt   = cnt;
endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: two-stage pixel pipeline (pattern, then blanking)
// with frame-synchronous mode switching.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter logic [11:0] H_DISP     = 12'd640,
  parameter logic [11:0] V_DISP     = 12'd480,
  parameter int          COLOR_W    = COLOR_W_DEF,
  parameter int          CHECK_LOG2 = 5,
  parameter int          FCNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   display_enable,
  input  logic [11:0]            pixel_x,
  input  logic [11:0]            pixel_y,
  input  logic [1:0]             mode_req,
  input  logic                   mode_req_valid,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  output logic                   mode_busy,
  output logic [FCNT_W-1:0]      o_frame_cnt,
  output logic [COLOR_W-1:0]     o_vga_r,
  output logic [COLOR_W-1:0]     o_vga_g,
  output logic [COLOR_W-1:0]     o_vga_b
);
  localparam int          CW3   = 3 * COLOR_W;
  localparam logic [11:0] BAR_W = H_DISP / 12'd8;

  vga_mode_if #(.FCNT_W(FCNT_W)) mif ();

  assign mif.mode_req       = mode_e'(mode_req);
  assign mif.mode_req_valid = mode_req_valid;
  assign mif.frame_end      = display_enable && (pixel_x == H_DISP - 12'd1)
                                             && (pixel_y == V_DISP - 12'd1);
  assign mode_busy          = mif.mode_busy;
  assign o_frame_cnt        = mif.frame_cnt;

  vga_mode_ctrl #(.FCNT_W(FCNT_W)) u_mode_ctrl (
    .clk   (clk),
    .reset (reset),
    .ctl   (mif.slave)
  );

  logic [11:0]    bar_q;
  logic [2:0]     bar_idx;
  logic [CW3-1:0] grad, pat;
  logic [CW3-1:0] color_s1, rgb_q;
  logic           de_s1;

  assign bar_q   = pixel_x / BAR_W;
  assign bar_idx = (bar_q > 12'd7) ? 3'd7 : bar_q[2:0];
  assign grad    = CW3'(pixel_x) + CW3'(1) + CW3'(mif.frame_cnt);

  always_comb begin
    pat = '0;
    unique case (mif.active_mode)
      MODE_GRADIENT: pat = grad;
      MODE_BARS:     pat = {{COLOR_W{bar_idx[2]}}, {COLOR_W{bar_idx[1]}}, {COLOR_W{bar_idx[0]}}};
      MODE_CHECKER:  pat = (pixel_x[CHECK_LOG2] ^ pixel_y[CHECK_LOG2]) ? {CW3{1'b1}} : {CW3{1'b0}};
      default:       pat = solid_rgb;
    endcase
  end

  // Stage 1 latches the pattern; stage 2 applies blanking from the delayed enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      color_s1 <= '0;
      de_s1    <= 1'b0;
      rgb_q    <= '0;
    end else begin
      color_s1 <= pat;
      de_s1    <= display_enable;
      rgb_q    <= de_s1 ? color_s1 : '0;
    end
  end

  assign {o_vga_r, o_vga_g, o_vga_b} = rgb_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen with a frame-level reference model checked every cycle.
module tb_vga_pattern_gen;
  import vga_pkg::*;

  localparam int HD = 640;
  localparam int VD = 480;
  localparam int FW = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        de = 1'b0;
  logic [11:0] px = '0, py = '0;
  logic [11:0] solid = 12'hA5C;
  logic [3:0]  r, g, b;
  logic [11:0] rgb;

  int total = 0;
  int bad   = 0;

  vga_mode_if #(.FCNT_W(FW)) req_if ();

  always #5 clk = ~clk;

  vga_pattern_gen dut (
    .clk            (clk),
    .reset          (reset),
    .display_enable (de),
    .pixel_x        (px),
    .pixel_y        (py),
    .mode_req       (req_if.mode_req),
    .mode_req_valid (req_if.mode_req_valid),
    .solid_rgb      (solid),
    .mode_busy      (req_if.mode_busy),
    .o_frame_cnt    (req_if.frame_cnt),
    .o_vga_r        (r),
    .o_vga_g        (g),
    .o_vga_b        (b)
  );

  assign rgb = {r, g, b};

  // Reference model: what the pixel must look like from mode rules alone.
  int          m_mode, m_pend, m_cnt;
  bit          m_busy;
  bit          started = 1'b0;
  logic [11:0] m_s1, m_out;

  assign req_if.active_mode = mode_e'(m_mode[1:0]);
  assign req_if.frame_end   = de && (int'(px) == HD - 1) && (int'(py) == VD - 1);

  function automatic logic [11:0] pat(input int mode, input int x, input int y, input int cnt);
    int idx;
    logic [11:0] c;
    c = 12'h000;
    case (mode)
      0: c = 12'((x + 1 + cnt) % 4096);
      1: begin
        idx = x / (HD / 8);
        if (idx > 7) idx = 7;
        if ((idx & 4) != 0) c = c | 12'hF00;
        if ((idx & 2) != 0) c = c | 12'h0F0;
        if ((idx & 1) != 0) c = c | 12'h00F;
      end
      2: c = ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 12'hFFF : 12'h000;
      default: c = solid;
    endcase
    return c;
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    if (reset) begin
      m_mode = 0; m_pend = 0; m_busy = 1'b0; m_cnt = 0;
      m_s1 = '0; m_out = '0;
    end else begin
      m_out = m_s1;
      m_s1  = de ? pat(m_mode, int'(px), int'(py), m_cnt) : 12'h000;
      if (de && int'(px) == HD - 1 && int'(py) == VD - 1) begin
        if (m_busy) m_mode = m_pend;
        m_busy = 1'b0;
        m_cnt  = (m_cnt + 1) % 256;
      end
      if (req_if.mode_req_valid) begin
        m_pend = int'(req_if.mode_req);
        m_busy = 1'b1;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("model_rgb",  32'(rgb), 32'(m_out));
      check("model_busy", 32'(req_if.mode_busy), 32'(m_busy));
      check("model_cnt",  32'(req_if.frame_cnt), 32'(m_cnt));
    end
  end

  task automatic drive(input bit d, input int x, input int y, input bit v = 1'b0, input int rq = 0);
    de = d;
    px = 12'(x);
    py = 12'(y);
    req_if.mode_req_valid = v;
    req_if.mode_req = mode_e'(rq[1:0]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    req_if.mode_req_valid = 1'b0;
    req_if.mode_req = MODE_GRADIENT;
    reset = 1'b1; de = 1'b1; px = 12'd5; py = 12'd0;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_rgb",  32'(rgb), 32'h0);
    check("rst_busy", 32'(req_if.mode_busy), 32'h0);
    check("rst_cnt",  32'(req_if.frame_cnt), 32'h0);
    reset = 1'b0;

    // Gradient latency and blanking
    drive(1, 5, 0);  check("grad_lat1", 32'(rgb), 32'h000);
    drive(0, 5, 0);  check("grad_x5",   32'(rgb), 32'h006);
    drive(0, 0, 0);  check("grad_de0",  32'(rgb), 32'h000);

    // Handshake: checker requested mid-frame
    drive(1, 100, 10, 1, 2); check("hs_busy_set",  32'(req_if.mode_busy), 32'h1);
    drive(1, 101, 10);       check("hs_grad100",   32'(rgb), 32'h065);
                             check("hs_busy_pend", 32'(req_if.mode_busy), 32'h1);
    drive(1, 639, 479);      check("hs_busy_clr",  32'(req_if.mode_busy), 32'h0);
                             check("hs_grad101",   32'(rgb), 32'h066);
    drive(1, 0, 0);          check("hs_fe_grad",   32'(rgb), 32'h280);
                             check("hs_cnt1",      32'(req_if.frame_cnt), 32'h1);
    drive(1, 32, 0);         check("hs_chk00",     32'(rgb), 32'h000);
    drive(0, 0, 0);          check("hs_chk32",     32'(rgb), 32'hFFF);

    // Bars
    drive(0, 0, 0, 1, 1);
    drive(1, 639, 479);
    drive(1, 85, 0);
    drive(1, 639, 0);        check("bar85",  32'(rgb), 32'h00F);
    drive(0, 0, 0);          check("bar639", 32'(rgb), 32'hFFF);

    // Collision: last request wins, request on frame_end waits a frame
    drive(0, 0, 0, 1, 3);
    drive(0, 0, 0, 1, 1);
    drive(1, 639, 479, 1, 2); check("col_busy", 32'(req_if.mode_busy), 32'h1);
    drive(1, 85, 0);
    drive(1, 32, 0);          check("col_bars", 32'(rgb), 32'h00F);
    drive(1, 639, 479);       check("col_bar32", 32'(rgb), 32'h000);
    drive(1, 32, 0);          check("col_idle", 32'(req_if.mode_busy), 32'h0);
    drive(0, 0, 0);           check("col_chk",  32'(rgb), 32'hFFF);

    // Solid
    drive(0, 0, 0, 1, 3);
    drive(1, 639, 479);
    drive(1, 7, 7);
    drive(0, 0, 0);           check("solid", 32'(rgb), 32'hA5C);
    drive(0, 0, 0);           check("solid_blank", 32'(rgb), 32'h000);

    // Reset mid-request with a loaded pipeline
    drive(0, 0, 0, 1, 1);
    drive(1, 200, 0);
    reset = 1'b1;
    drive(1, 5, 0);           check("mrst_rgb",  32'(rgb), 32'h000);
                              check("mrst_busy", 32'(req_if.mode_busy), 32'h0);
                              check("mrst_cnt",  32'(req_if.frame_cnt), 32'h0);
    reset = 1'b0;
    drive(1, 5, 0);           check("mrst_flush", 32'(rgb), 32'h000);
    drive(1, 639, 479);       check("mrst_grad", 32'(rgb), 32'h006);
    drive(1, 0, 0);           check("mrst_fe",   32'(rgb), 32'h280);
    drive(0, 0, 0);           check("mrst_nopend", 32'(rgb), 32'h002);

    // Frame counter wrap
    reset = 1'b1;
    drive(0, 0, 0);
    reset = 1'b0;
    repeat (255) drive(1, 639, 479);
    check("cnt_255", 32'(req_if.frame_cnt), 32'd255);
    drive(1, 639, 479);
    check("cnt_wrap", 32'(req_if.frame_cnt), 32'd0);
    repeat (2) drive(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
